// File: rtl/spi_word_master.sv
// spi_word_master
//   SPI master that serialises DATA_W-bit words onto mosi while capturing miso
//   in full duplex. It supports all four CPOL/CPHA modes and drives an
//   active-low slave select. Words arrive over a valid/ready handshake.
//   Completion is reported with a one-cycle done pulse, and a killed frame is
//   reported with a one-cycle aborted pulse.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   tx_data, tx_valid  word to send and its valid flag
//   tx_ready           high while IDLE (combinational, low during rst)
//   abort              terminate the frame in progress
//   rx_data            word captured from miso, updated together with done
//   done, aborted      one-cycle completion / abort pulses
//   busy               high from accept until the return to IDLE
//   ss_n, sclk, mosi   SPI outputs (all registered)
//   miso               SPI input (already synchronised upstream)

module spi_word_master #(
  parameter int DATA_W    = 8,
  parameter int DIV       = 4,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1,
  parameter int GAP_CYC   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              abort,
  output logic [DATA_W-1:0] rx_data,
  output logic              done,
  output logic              aborted,
  output logic              busy,
  output logic              ss_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int CNT_MAX = (DIV > GAP_CYC) ? DIV : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int HALF_W  = $clog2(2 * DATA_W + 1);

  localparam logic              SCLK_IDLE = (CPOL != 0);
  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [HALF_W-1:0]   half;
  logic [DATA_W-1:0]   tx_sh;
  logic [DATA_W-1:0]   rx_sh;
  logic                sample_now;

  // Bit-order helpers: the same order is used for sending and assembling, so
  // a loopback returns the transmitted word unchanged.
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                  input logic b);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  assign tx_ready = (state == IDLE) && !rst;

  // Even half-periods end on a leading sclk edge and odd ones on a trailing edge.
  // CPHA=0 samples on leading edges; CPHA=1 samples on trailing edges.
  assign sample_now = (CPHA == 0) ? !half[0] : half[0];

  // The frame sequencer and every registered output. done and aborted default
  // low, so each one lasts exactly the one cycle in which it is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      half    <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      done    <= 1'b0;
      aborted <= 1'b0;
      busy    <= 1'b0;
      ss_n    <= 1'b1;
      sclk    <= SCLK_IDLE;
      mosi    <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      // abort is checked first so that it takes priority over a frame ending in the same cycle.
      if (abort && (state inside {SETUP, SHIFT, HOLD})) begin
        state   <= GAP;
        cnt     <= '0;
        ss_n    <= 1'b1;
        sclk    <= SCLK_IDLE;
        mosi    <= 1'b0;
        aborted <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (tx_valid && tx_ready) begin
              state <= SETUP;
              cnt   <= '0;
              ss_n  <= 1'b0;
              busy  <= 1'b1;
              rx_sh <= '0;
              // CPHA=0 presents the first bit before the first (sampling) edge.
              if (CPHA == 0) begin
                mosi  <= first_bit(tx_data);
                tx_sh <= shift_out(tx_data);
              end else begin
                mosi  <= 1'b0;
                tx_sh <= tx_data;
              end
            end
          end
          SETUP: begin
            if (cnt == DIV_LAST) begin
              state <= SHIFT;
              cnt   <= '0;
              half  <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SHIFT: begin
            if (cnt == DIV_LAST) begin
              cnt  <= '0;
              sclk <= ~sclk;
              if (sample_now) begin
                rx_sh <= shift_in(rx_sh, miso);
              end else if (half != HALF_LAST) begin
                // The final trailing edge in CPHA=0 has no next bit, so mosi holds.
                mosi  <= first_bit(tx_sh);
                tx_sh <= shift_out(tx_sh);
              end
              if (half == HALF_LAST) begin
                state <= HOLD;
              end else begin
                half <= half + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HOLD: begin
            if (cnt == DIV_LAST) begin
              state   <= GAP;
              cnt     <= '0;
              ss_n    <= 1'b1;
              mosi    <= 1'b0;
              done    <= 1'b1;
              rx_data <= rx_sh;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GAP: begin
            if (cnt == GAP_LAST) begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_word_master.sv
// tb_spi_word_master
//   Five spi_word_master instances (8-bit, DIV=4, GAP_CYC=2):
//     0: mode 0 MSB-first   1: mode 1   2: mode 2   3: mode 3   4: mode 0 LSB-first
//   Each miso is either looped back from its own mosi or driven by a
//   behavioural MSB-first slave that returns 8'h3C. Expected rx words go into a
//   scoreboard queue when a frame is launched and are popped on done.

module tb_spi_word_master;

  localparam int NI      = 5;
  localparam int DIV     = 4;
  localparam int GAP_CYC = 2;
  localparam int FRAME   = (2 * 8 + 2) * DIV;          // ss_n low cycles
  localparam int SPACING = 1 + FRAME + GAP_CYC;         // accept-to-accept
  localparam logic [NI-1:0] CPOL_V = 5'b01100;
  localparam logic [NI-1:0] CPHA_V = 5'b01010;
  localparam logic [NI-1:0] MSB_V  = 5'b01111;
  localparam logic [7:0]    SLAVE_WORD = 8'h3C;

  logic clk;
  logic rst;
  logic [7:0]    tx_data;
  logic [NI-1:0] tx_valid, tx_ready, abort, done, aborted, busy, ss_n, sclk, mosi, miso;
  logic [NI-1:0] loop_sel, s_miso;
  logic [7:0]    rx_data [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign miso[g] = loop_sel[g] ? mosi[g] : s_miso[g];
    spi_word_master #(
      .DATA_W(8), .DIV(DIV), .CPOL(CPOL_V[g] ? 1 : 0), .CPHA(CPHA_V[g] ? 1 : 0),
      .MSB_FIRST(MSB_V[g] ? 1 : 0), .GAP_CYC(GAP_CYC)
    ) u_dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]), .abort(abort[g]), .rx_data(rx_data[g]),
      .done(done[g]), .aborted(aborted[g]), .busy(busy[g]), .ss_n(ss_n[g]),
      .sclk(sclk[g]), .mosi(mosi[g]), .miso(miso[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         inst;
    logic [7:0] tx;
    logic [7:0] rx;
    bit         loopback;
    int         mosi_hi;
  } vec_t;

  typedef struct {
    int         inst;
    logic [7:0] rx;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int   low_cnt[NI], rise_cnt[NI], edge_cnt[NI], hi_cnt[NI], done_cnt[NI];
  int   ab_cnt[NI], rdy_cnt[NI], high_run[NI], last_high_run[NI], unstable[NI];
  logic sclk_prev[NI], ss_prev[NI], mosi_prev[NI];
  logic [7:0] s_tx[NI], slave_rx[NI];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic failTimeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out waiting, want event", name);
  endtask

  // One sample point per clock, on the falling edge. It updates the event
  // counters, runs the slave model (which sees sclk edges half a cycle late,
  // well inside the DIV-cycle half-period), and drains the scoreboard on done.
  task automatic stepCycle();
    exp_t e;
    logic leading;
    @(negedge clk);
    cyc++;
    for (int g = 0; g < NI; g++) begin
      if (ss_n[g] === 1'b0) low_cnt[g]++;
      if (mosi[g] === 1'b1) hi_cnt[g]++;
      if (tx_ready[g] === 1'b1) rdy_cnt[g]++;
      if (aborted[g] === 1'b1) ab_cnt[g]++;
      if (sclk[g] === 1'b1 && sclk_prev[g] === 1'b0) rise_cnt[g]++;
      if (sclk[g] !== sclk_prev[g]) edge_cnt[g]++;
      if (ss_n[g] === 1'b1) high_run[g]++;
      else if (high_run[g] != 0) begin
        last_high_run[g] = high_run[g];
        high_run[g] = 0;
      end
      if (ss_prev[g] === 1'b1 && ss_n[g] === 1'b0) begin
        s_tx[g] = SLAVE_WORD;
        slave_rx[g] = 8'h00;
        if (!CPHA_V[g]) begin
          s_miso[g] = s_tx[g][7];
          s_tx[g] = {s_tx[g][6:0], 1'b0};
        end
      end else if (ss_n[g] === 1'b0 && sclk[g] !== sclk_prev[g]) begin
        leading = (sclk[g] !== CPOL_V[g]);
        if (leading == !CPHA_V[g]) begin
          if (mosi[g] !== mosi_prev[g]) unstable[g]++;
          slave_rx[g] = {slave_rx[g][6:0], mosi[g]};
        end else begin
          s_miso[g] = s_tx[g][7];
          s_tx[g] = {s_tx[g][6:0], 1'b0};
        end
      end
      if (done[g] === 1'b1) begin
        done_cnt[g]++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", g, 32'hFFFF);
        end else begin
          e = sb.pop_front();
          checkOutput("sb_inst", g, e.inst);
          checkOutput("sb_rx", rx_data[g], e.rx);
        end
      end
      sclk_prev[g] = sclk[g];
      ss_prev[g]   = ss_n[g];
      mosi_prev[g] = mosi[g];
    end
  endtask

  task automatic applyStimulus(input int g, input logic [7:0] data, input logic [7:0] exp_rx,
                               input bit lb, input bit push);
    exp_t e;
    bit ok = 0;
    loop_sel[g] = lb;
    tx_data = data;
    tx_valid[g] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (tx_ready[g] === 1'b1) begin
        ok = 1;
        break;
      end
      stepCycle();
    end
    if (!ok) begin
      failTimeout("accept");
      tx_valid[g] = 1'b0;
      return;
    end
    if (push) begin
      e.inst = g;
      e.rx = exp_rx;
      sb.push_back(e);
    end
    stepCycle();
    tx_valid[g] = 1'b0;
  endtask

  task automatic waitIdle(input int g);
    for (int i = 0; i < 400; i++) begin
      stepCycle();
      if (busy[g] === 1'b0) return;
    end
    failTimeout("idle");
  endtask

  task automatic waitEdges(input int g, input int n);
    int base = edge_cnt[g];
    for (int i = 0; i < 400; i++) begin
      if (edge_cnt[g] - base >= n) return;
      stepCycle();
    end
    failTimeout("sclk_edges");
  endtask

  vec_t vecs[7];
  int   acc[3];

  initial begin
    int b_low, b_rise, b_hi, b_done, b_ab, b_uns, b_rdy, g;
    vecs[0] = '{0, 8'hA5, 8'hA5, 1'b1, 40};
    vecs[1] = '{0, 8'hC3, 8'h3C, 1'b0, 40};
    vecs[2] = '{1, 8'hC3, 8'h3C, 1'b0, 32};
    vecs[3] = '{2, 8'hC3, 8'h3C, 1'b0, 40};
    vecs[4] = '{3, 8'hC3, 8'h3C, 1'b0, 32};
    vecs[5] = '{4, 8'h01, 8'h01, 1'b1, 12};
    vecs[6] = '{4, 8'hB2, 8'hB2, 1'b1, 36};
    for (int i = 0; i < NI; i++) begin
      low_cnt[i] = 0; rise_cnt[i] = 0; edge_cnt[i] = 0; hi_cnt[i] = 0; done_cnt[i] = 0;
      ab_cnt[i] = 0; rdy_cnt[i] = 0; high_run[i] = 0; last_high_run[i] = 0; unstable[i] = 0;
      sclk_prev[i] = 1'bx; ss_prev[i] = 1'bx; mosi_prev[i] = 1'bx;
      s_tx[i] = 8'h00; slave_rx[i] = 8'h00;
    end
    rst = 1'b1;
    tx_data = 8'h00;
    tx_valid = '0;
    abort = '0;
    loop_sel = '0;
    s_miso = '0;

    // Reset values while rst is held, then tx_ready in the first cycle after.
    repeat (3) stepCycle();
    checkOutput("rst_ss_n", ss_n, 5'b11111);
    checkOutput("rst_sclk", sclk, CPOL_V);
    checkOutput("rst_mosi", mosi, 5'b00000);
    checkOutput("rst_done", done, 5'b00000);
    checkOutput("rst_aborted", aborted, 5'b00000);
    checkOutput("rst_busy", busy, 5'b00000);
    checkOutput("rst_rx_data", rx_data[0], 8'h00);
    checkOutput("rst_tx_ready", tx_ready, 5'b00000);
    rst = 1'b0;
    stepCycle();
    checkOutput("tx_ready_after_rst", tx_ready, 5'b11111);

    // Table of single frames across modes and bit orders.
    for (int v = 0; v < 7; v++) begin
      g = vecs[v].inst;
      b_low = low_cnt[g]; b_rise = rise_cnt[g]; b_hi = hi_cnt[g];
      b_done = done_cnt[g]; b_ab = ab_cnt[g]; b_uns = unstable[g];
      applyStimulus(g, vecs[v].tx, vecs[v].rx, vecs[v].loopback, 1'b1);
      waitIdle(g);
      checkOutput("ss_low_cycles", low_cnt[g] - b_low, FRAME);
      checkOutput("sclk_rises", rise_cnt[g] - b_rise, 8);
      checkOutput("done_count", done_cnt[g] - b_done, 1);
      checkOutput("abort_count", ab_cnt[g] - b_ab, 0);
      checkOutput("mosi_high_cycles", hi_cnt[g] - b_hi, vecs[v].mosi_hi);
      checkOutput("sclk_idle", sclk[g], CPOL_V[g]);
      checkOutput("rx_data", rx_data[g], vecs[v].rx);
      if (MSB_V[g]) begin
        checkOutput("slave_saw_tx", slave_rx[g], vecs[v].tx);
        checkOutput("mosi_stable", unstable[g] - b_uns, 0);
      end
    end

    // tx_valid held high: three back-to-back frames. ss_n stays high for the
    // GAP cycles plus the IDLE cycle in which the next word is accepted.
    loop_sel[0] = 1'b1;
    tx_data = 8'h5A;
    tx_valid[0] = 1'b1;
    b_done = done_cnt[0];
    b_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      acc[k] = -1;
      for (int i = 0; i < 200; i++) begin
        if (tx_ready[0] === 1'b1) begin
          acc[k] = cyc;
          break;
        end
        stepCycle();
      end
      if (acc[k] < 0) failTimeout("b2b_accept");
      if (k == 0) b_rdy = rdy_cnt[0];
      if (k == 2) checkOutput("b2b_ready_pulses", rdy_cnt[0] - b_rdy, 2);
      sb.push_back('{0, 8'h5A});
      stepCycle();
    end
    tx_valid[0] = 1'b0;
    checkOutput("b2b_spacing1", acc[1] - acc[0], SPACING);
    checkOutput("b2b_spacing2", acc[2] - acc[1], SPACING);
    checkOutput("b2b_ss_high", last_high_run[0], GAP_CYC + 1);
    waitIdle(0);
    checkOutput("b2b_done_count", done_cnt[0] - b_done, 3);

    // abort while IDLE does nothing.
    abort[0] = 1'b1;
    stepCycle();
    abort[0] = 1'b0;
    checkOutput("idle_abort_pulse", aborted[0], 1'b0);
    checkOutput("idle_abort_busy", busy[0], 1'b0);

    // abort after the third sclk edge.
    b_done = done_cnt[0]; b_ab = ab_cnt[0];
    applyStimulus(0, 8'h0F, 8'h00, 1'b1, 1'b0);
    waitEdges(0, 3);
    abort[0] = 1'b1;
    stepCycle();
    abort[0] = 1'b0;
    checkOutput("abort_ss_n", ss_n[0], 1'b1);
    checkOutput("abort_pulse", aborted[0], 1'b1);
    checkOutput("abort_no_done", done[0], 1'b0);
    checkOutput("abort_sclk", sclk[0], 1'b0);
    checkOutput("abort_mosi", mosi[0], 1'b0);
    checkOutput("abort_rx_hold", rx_data[0], 8'h5A);
    checkOutput("abort_busy", busy[0], 1'b1);
    stepCycle();
    checkOutput("abort_one_cycle", aborted[0], 1'b0);
    waitIdle(0);
    checkOutput("abort_done_count", done_cnt[0] - b_done, 0);
    checkOutput("abort_count", ab_cnt[0] - b_ab, 1);
    applyStimulus(0, 8'h96, 8'h96, 1'b1, 1'b1);
    waitIdle(0);
    checkOutput("post_abort_done", done_cnt[0] - b_done, 1);
    checkOutput("post_abort_rx", rx_data[0], 8'h96);

    // rst for one cycle in the middle of SHIFT.
    b_done = done_cnt[0]; b_ab = ab_cnt[0];
    applyStimulus(0, 8'h33, 8'h00, 1'b1, 1'b0);
    waitEdges(0, 5);
    rst = 1'b1;
    stepCycle();
    checkOutput("midrst_ss_n", ss_n[0], 1'b1);
    checkOutput("midrst_sclk", sclk[0], 1'b0);
    checkOutput("midrst_mosi", mosi[0], 1'b0);
    checkOutput("midrst_busy", busy[0], 1'b0);
    checkOutput("midrst_rx", rx_data[0], 8'h00);
    checkOutput("midrst_tx_ready", tx_ready[0], 1'b0);
    rst = 1'b0;
    stepCycle();
    checkOutput("midrst_ready_after", tx_ready[0], 1'b1);
    repeat (100) stepCycle();
    checkOutput("midrst_no_done", done_cnt[0] - b_done, 0);
    checkOutput("midrst_no_abort", ab_cnt[0] - b_ab, 0);
    checkOutput("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
